// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: FSM state encoding and the
// width helpers that keep the sequencer and the selection mux in agreement.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Ceiling log2 with a floor of 1, so a 2-entry mux still gets a 1-bit select.
    function automatic int clogb2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Full product width plus growth for N terms plus one bit of headroom for the bias.
    function automatic int acc_width(input int n, input int dw);
        return (2 * dw) + clogb2(n) + 1;
    endfunction

endpackage

// File: rtl/neuron_mac_sequencer_relu_saturate.sv
// ReLU followed by arithmetic right shift and saturation to the positive
// half of a DW-bit signed range. Purely combinational; shared by later layers.
module relu_saturate
    import neuron_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int DW    = 8,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0] din,
    output logic [DW-1:0]    dout
);

    localparam logic [ACC_W-1:0] MAX_POS = ACC_W'((64'd1 << (DW - 1)) - 64'd1);

    logic [ACC_W-1:0] shifted_s;

    // Clamp negatives to zero, scale down, then cap at the largest positive code.
    always_comb begin
        shifted_s = $unsigned($signed(din) >>> SHIFT);
        if (din[ACC_W-1]) begin
            dout = {DW{1'b0}};
        end else if (shifted_s > MAX_POS) begin
            dout = MAX_POS[DW-1:0];
        end else begin
            dout = shifted_s[DW-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Walks the selection mux through N input/weight pairs, accumulates the signed
// products, adds the bias and presents the raw sum plus its activation.
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int SHIFT = 0,
    parameter int SEL_W = clogb2(N),
    parameter int ACC_W = acc_width(N, DW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    bias,
    output logic [SEL_W-1:0] sel,
    input  logic [DW-1:0]    in_data,
    input  logic [DW-1:0]    w_data,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [DW-1:0]    act_out
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(32'd1);

    state_e             state_r, state_s;
    logic [ACC_W-1:0]   acc_r, acc_s;
    logic [DW-1:0]      bias_r, bias_s;
    logic [SEL_W-1:0]   sel_r, sel_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [ACC_W-1:0]   result_r, result_s;
    logic [DW-1:0]      act_r, act_s;

    logic signed [2*DW-1:0] prod_s;
    logic [ACC_W-1:0]       prod_ext_s;
    logic [ACC_W-1:0]       bias_ext_s;
    logic [ACC_W-1:0]       sum_s;
    logic [DW-1:0]          act_sat_s;

    assign prod_s     = $signed(in_data) * $signed(w_data);
    assign prod_ext_s = {{(ACC_W - 2*DW){prod_s[2*DW-1]}}, prod_s};
    assign bias_ext_s = {{(ACC_W - DW){bias_r[DW-1]}}, bias_r};
    assign sum_s      = acc_r + bias_ext_s;

    relu_saturate #(
        .ACC_W (ACC_W),
        .DW    (DW),
        .SHIFT (SHIFT)
    ) u_relu_saturate (
        .din  (sum_s),
        .dout (act_sat_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the last element index ends accumulation so sel never wraps.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (sel_r == LAST_SEL) begin
                    state_s = FINISH;
                end else begin
                    state_s = ACCUM;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered datapath and outputs for each state.
    always_comb begin
        acc_s    = acc_r;
        bias_s   = bias_r;
        sel_s    = sel_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        result_s = result_r;
        act_s    = act_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    bias_s = bias;
                    acc_s  = {ACC_W{1'b0}};
                    sel_s  = {SEL_W{1'b0}};
                    busy_s = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ACCUM: begin
                acc_s = acc_r + prod_ext_s;
                if (sel_r == LAST_SEL) begin
                    sel_s = {SEL_W{1'b0}};
                end else begin
                    sel_s = sel_r + SEL_ONE;
                end
            end
            FINISH: begin
                result_s = sum_s;
                act_s    = act_sat_s;
                done_s   = 1'b1;
                busy_s   = 1'b0;
            end
            default: begin
                sel_s  = {SEL_W{1'b0}};
                busy_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            bias_r   <= {DW{1'b0}};
            sel_r    <= {SEL_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {ACC_W{1'b0}};
            act_r    <= {DW{1'b0}};
        end else begin
            acc_r    <= acc_s;
            bias_r   <= bias_s;
            sel_r    <= sel_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            result_r <= result_s;
            act_r    <= act_s;
        end
    end

    assign sel     = sel_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign act_out = act_r;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench: four sequencer instances (N=2, N=3, N=4, N=4 with SHIFT=10),
// each fed by a mux model. Stimulus pushes expected results; a monitor pops on done.
module tb_neuron_mac_sequencer;
    import neuron_pkg::*;

    localparam int NI = 4;
    localparam int NT [NI] = '{2, 3, 4, 4};
    localparam int ST [NI] = '{0, 0, 0, 10};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a [NI];
    logic [7:0]  bias_a  [NI];
    logic [7:0]  in_mem  [NI][4];
    logic [7:0]  w_mem   [NI][4];
    logic [1:0]  sel_a   [NI];
    logic        busy_a  [NI];
    logic        done_a  [NI];
    logic [31:0] res_a   [NI];
    logic [7:0]  act_a   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NN = NT[g];
        localparam int SW = clogb2(NN);
        localparam int AW = acc_width(NN, 8);
        logic [SW-1:0] sel_g;
        logic [7:0]    in_g;
        logic [7:0]    w_g;
        logic [AW-1:0] res_g;

        assign in_g     = in_mem[g][2'(sel_g)];
        assign w_g      = w_mem[g][2'(sel_g)];
        assign sel_a[g] = 2'(sel_g);
        assign res_a[g] = {{(32 - AW){res_g[AW-1]}}, res_g};

        neuron_mac_sequencer #(
            .N     (NN),
            .DW    (8),
            .SHIFT (ST[g])
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_a[g]),
            .bias    (bias_a[g]),
            .sel     (sel_g),
            .in_data (in_g),
            .w_data  (w_g),
            .busy    (busy_a[g]),
            .done    (done_a[g]),
            .result  (res_g),
            .act_out (act_a[g])
        );
    end

    typedef struct {
        int inst;
        int res;
        int act;
    } exp_t;

    exp_t exp_q [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   busy_cnt  [NI] = '{default: 0};
    int   last_done [NI] = '{default: -1000};
    int   wd = 0;

    task automatic check(input string name, input int g, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s inst=%0d actual=%0d required=%0d", name, g, act, req);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        cyc++;
        if (!rst_n) begin
            for (int g = 0; g < NI; g++) begin
                check("rst_sel_busy_done", g, longint'({sel_a[g], busy_a[g], done_a[g]}), 0);
                check("rst_result", g, longint'($signed(res_a[g])), 0);
                check("rst_act_out", g, longint'(act_a[g]), 0);
                busy_cnt[g] = 0;
            end
            wd = 0;
        end else begin
            for (int g = 0; g < NI; g++) begin
                if (done_a[g]) begin
                    check("done_busy_overlap", g, longint'(busy_a[g]), 0);
                    check("latency_busy_cycles", g, busy_cnt[g], NT[g] + 1);
                    if (cyc - last_done[g] <= 10) begin
                        check("b2b_period", g, cyc - last_done[g], NT[g] + 2);
                    end
                    last_done[g] = cyc;
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", g, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_instance", g, g, e.inst);
                        check("result", g, longint'($signed(res_a[g])), e.res);
                        check("act_out", g, longint'(act_a[g]), e.act);
                    end
                    wd = 0;
                end
                if (busy_a[g]) begin
                    check("sel_seq", g, longint'(sel_a[g]), (busy_cnt[g] < NT[g]) ? busy_cnt[g] : 0);
                    busy_cnt[g] = busy_cnt[g] + 1;
                end else begin
                    busy_cnt[g] = 0;
                end
            end
            if (exp_q.size() > 0) begin
                wd++;
                if (wd > 60) begin
                    check("done_timeout", exp_q[0].inst, 0, 1);
                    void'(exp_q.pop_front());
                    wd = 0;
                end
            end else begin
                wd = 0;
            end
        end
    end

    task automatic load(input int g, input int ins [4], input int wts [4]);
        for (int i = 0; i < 4; i++) begin
            in_mem[g][i] = 8'(ins[i]);
            w_mem[g][i]  = 8'(wts[i]);
        end
    endtask

    // Pulse start for one cycle; bias is scrambled right after acceptance.
    task automatic issue(input int g, input int b, input int er, input int ea, input bit expect_done);
        exp_t e;
        if (expect_done) begin
            e.inst = g;
            e.res  = er;
            e.act  = ea;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bias_a[g]  = 8'(b);
        start_a[g] = 1'b1;
        @(negedge clk);
        start_a[g] = 1'b0;
        bias_a[g]  = 8'd100;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            start_a[g] = 1'b0;
            bias_a[g]  = 8'd0;
            for (int i = 0; i < 4; i++) begin
                in_mem[g][i] = 8'd99;
                w_mem[g][i]  = 8'd99;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset two cycles into accumulation on the N=4 instance, then a clean run.
        load(2, '{127, 127, 127, 127}, '{127, 127, 127, 127});
        issue(2, 127, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(2, 127, 64643, 127, 1'b1);
        drain();

        // Same vector with SHIFT=10.
        load(3, '{127, 127, 127, 127}, '{127, 127, 127, 127});
        issue(3, 127, 64643, 63, 1'b1);
        drain();

        // N=2 basic, ReLU clamp, extreme operands.
        load(0, '{3, 4, 99, 99}, '{5, -2, 99, 99});
        issue(0, 1, 8, 8, 1'b1);
        drain();
        load(0, '{-10, 2, 99, 99}, '{10, 3, 99, 99});
        issue(0, -5, -99, 0, 1'b1);
        drain();
        load(0, '{-128, -128, 99, 99}, '{-128, -128, 99, 99});
        issue(0, -128, 32640, 127, 1'b1);
        drain();

        // N=3: start pulsed while busy must be ignored.
        load(1, '{1, 2, 3, 99}, '{4, 5, 6, 99});
        issue(1, 0, 32, 32, 1'b1);
        @(negedge clk);
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        drain();

        // N=3: start held high gives three back-to-back evaluations.
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{inst: 1, res: 30, act: 30});
        end
        @(negedge clk);
        bias_a[1]  = 8'(-2);
        start_a[1] = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        start_a[1] = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
